// File: rtl/dma.sv
// dma: single-port memory-access engine with an internal RAM.
//
// The engine serves one read or one write at a time. A level request is
// latched in IDLE, the access completes ACCESS_CYCLES edges later, and a
// one-cycle done strobe reports it. Read data stays on dataout until the
// next read completes.
//
// Ports:
//   clk           rising-edge clock
//   RST           synchronous active-low reset
//   address       word address of the request
//   data          write data
//   read_signal   read request (level)
//   write_signal  write request (level, wins over read)
//   dataout       registered read data
//   doneRead      one-cycle read-complete strobe
//   doneWrite     one-cycle write-complete strobe
//
// Configuration macro: DMA_ADDR_CHECK_EN
//   defined   - addresses >= DEPTH complete normally, but a write leaves the
//               RAM untouched and a read returns 0
//   undefined - the address is truncated to log2(DEPTH) bits (aliasing)
module dma #(
  parameter int ADDR_W        = 16,
  parameter int DATA_W        = 16,
  parameter int DEPTH         = 1024,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic              clk,
  input  logic              RST,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data,
  input  logic              read_signal,
  input  logic              write_signal,
  output logic [DATA_W-1:0] dataout,
  output logic              doneRead,
  output logic              doneWrite
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    READ_WAIT  = 2'd1,
    WRITE_WAIT = 2'd2
  } state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] dataout_q;
  logic              done_rd_q;
  logic              done_wr_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [IDX_W-1:0]  idx;
  logic              last_cnt;
  logic              in_range;
  logic              ram_we;

  assign idx      = addr_q[IDX_W-1:0];
  assign last_cnt = (cnt_q == LAST_CNT);

`ifdef DMA_ADDR_CHECK_EN
  assign in_range = ({1'b0, addr_q} < (ADDR_W+1)'(DEPTH));
`else
  assign in_range = 1'b1;
`endif

  // Address bits above the RAM index only matter for the range check.
  if (IDX_W < ADDR_W) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr_q[ADDR_W-1:IDX_W];
  end

  // The write lands on the same edge that raises doneWrite; reset in that
  // cycle suppresses it so an aborted access never reaches the RAM.
  assign ram_we = RST && (state_q == WRITE_WAIT) && last_cnt && in_range;

  // RAM array: no reset, contents survive RST.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[idx] <= wdata_q;
    end
  end

  // Control FSM with registered outputs. The latched request (addr_q,
  // wdata_q) is datapath and deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (!RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dataout_q <= '0;
      done_rd_q <= 1'b0;
      done_wr_q <= 1'b0;
    end else begin
      done_rd_q <= 1'b0;
      done_wr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (write_signal) begin
            addr_q  <= address;
            wdata_q <= data;
            state_q <= WRITE_WAIT;
          end else if (read_signal) begin
            addr_q  <= address;
            state_q <= READ_WAIT;
          end
        end
        READ_WAIT: begin
          if (last_cnt) begin
            dataout_q <= in_range ? mem[idx] : '0;
            done_rd_q <= 1'b1;
            cnt_q     <= '0;
            state_q   <= IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        WRITE_WAIT: begin
          if (last_cnt) begin
            done_wr_q <= 1'b1;
            cnt_q     <= '0;
            state_q   <= IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign dataout   = dataout_q;
  assign doneRead  = done_rd_q;
  assign doneWrite = done_wr_q;

endmodule

// File: tb/tb_dma.sv
// tb_dma: directed self-checking bench for dma (ACCESS_CYCLES=2, DEPTH=1024).
// A request raised just after an edge is captured at the next edge (tick 1)
// and its done strobe is seen after tick 3.
module tb_dma;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  logic              clk;
  logic              RST;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data;
  logic              read_signal;
  logic              write_signal;
  logic [DATA_W-1:0] dataout;
  logic              doneRead;
  logic              doneWrite;

  int n_checks;
  int n_fail;

  dma #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(1024), .ACCESS_CYCLES(2)
  ) dut (
    .clk(clk), .RST(RST), .address(address), .data(data),
    .read_signal(read_signal), .write_signal(write_signal),
    .dataout(dataout), .doneRead(doneRead), .doneWrite(doneWrite)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle just past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a write and wait (bounded) for doneWrite; cyc = ticks taken, -1 on timeout.
  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                          output int cyc);
    cyc = -1;
    address = a; data = d; write_signal = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (doneWrite) begin
        cyc = k;
        break;
      end
    end
    write_signal = 1'b0;
  endtask

  // Issue a read and wait (bounded) for doneRead; cyc = ticks taken, -1 on timeout.
  task automatic do_read(input logic [ADDR_W-1:0] a, output int cyc);
    cyc = -1;
    address = a; read_signal = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (doneRead) begin
        cyc = k;
        break;
      end
    end
    read_signal = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    tick();
    tick();
    n_checks++;
    if (dataout !== 16'h0000) begin
      n_fail++; $display("FAIL reset_dataout: got %h expected 0000", dataout);
    end
    n_checks++;
    if (doneRead !== 1'b0) begin
      n_fail++; $display("FAIL reset_doneRead: got %b expected 0", doneRead);
    end
    n_checks++;
    if (doneWrite !== 1'b0) begin
      n_fail++; $display("FAIL reset_doneWrite: got %b expected 0", doneWrite);
    end
    RST = 1'b1;
    tick();
  endtask

  task automatic test_write_readback();
    logic [ADDR_W-1:0] addrs [3];
    logic [DATA_W-1:0] vals  [3];
    int cyc;
    addrs[0] = 16'd1; vals[0] = 16'hF0F0;
    addrs[1] = 16'd2; vals[1] = 16'hF00F;
    addrs[2] = 16'd9; vals[2] = 16'hA001;
    for (int i = 0; i < 3; i++) begin
      do_write(addrs[i], vals[i], cyc);
      n_checks++;
      if (cyc != 3) begin
        n_fail++; $display("FAIL wr_latency[%0d]: got %0d ticks expected 3", i, cyc);
      end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      do_read(addrs[i], cyc);
      n_checks++;
      if (cyc != 3 || dataout !== vals[i]) begin
        n_fail++; $display("FAIL readback[%0d]: got %h after %0d ticks expected %h after 3",
                           i, dataout, cyc, vals[i]);
      end
      tick();
      tick();
      n_checks++;
      if (dataout !== vals[i] || doneRead !== 1'b0) begin
        n_fail++; $display("FAIL hold[%0d]: got %h done=%b expected %h done=0",
                           i, dataout, doneRead, vals[i]);
      end
    end
  endtask

  task automatic test_latency();
    logic exp_rd;
    address = 16'd2; read_signal = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      exp_rd = (k == 3);
      n_checks++;
      if (doneRead !== exp_rd || doneWrite !== 1'b0) begin
        n_fail++; $display("FAIL latency_tick%0d: got rd=%b wr=%b expected rd=%b wr=0",
                           k, doneRead, doneWrite, exp_rd);
      end
      if (k == 3) read_signal = 1'b0;
    end
    n_checks++;
    if (dataout !== 16'hF00F) begin
      n_fail++; $display("FAIL latency_data: got %h expected f00f", dataout);
    end
  endtask

  task automatic test_priority();
    address = 16'd3; data = 16'hF001;
    read_signal = 1'b1; write_signal = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 3) begin
        n_checks++;
        if (doneWrite !== 1'b1 || doneRead !== 1'b0) begin
          n_fail++; $display("FAIL prio_write_first: got wr=%b rd=%b expected wr=1 rd=0",
                             doneWrite, doneRead);
        end
        write_signal = 1'b0;
      end
      if (k == 6) begin
        n_checks++;
        if (doneRead !== 1'b1 || doneWrite !== 1'b0 || dataout !== 16'hF001) begin
          n_fail++; $display("FAIL prio_read_after: got rd=%b wr=%b data=%h expected rd=1 wr=0 data=f001",
                             doneRead, doneWrite, dataout);
        end
      end
    end
    read_signal = 1'b0;
    tick();
  endtask

  task automatic test_midop_change();
    int cyc;
    do_write(16'd5, 16'h5555, cyc);
    tick();
    address = 16'd4; data = 16'h1234; write_signal = 1'b1;
    tick();
    address = 16'd5; data = 16'hBEEF; write_signal = 1'b0;
    tick();
    tick();
    n_checks++;
    if (doneWrite !== 1'b1) begin
      n_fail++; $display("FAIL midop_done: got %b expected 1", doneWrite);
    end
    tick();
    do_read(16'd4, cyc);
    n_checks++;
    if (dataout !== 16'h1234) begin
      n_fail++; $display("FAIL midop_latched: got %h expected 1234", dataout);
    end
    tick();
    do_read(16'd5, cyc);
    n_checks++;
    if (dataout !== 16'h5555) begin
      n_fail++; $display("FAIL midop_other_word: got %h expected 5555", dataout);
    end
    tick();
  endtask

  task automatic test_reset_abort();
    int cyc;
    do_write(16'd6, 16'h6666, cyc);
    tick();
    do_read(16'd6, cyc);
    tick();
    address = 16'd6; data = 16'hDEAD; write_signal = 1'b1;
    tick();
    RST = 1'b0; write_signal = 1'b0;
    tick();
    n_checks++;
    if (dataout !== 16'h0000 || doneWrite !== 1'b0 || doneRead !== 1'b0) begin
      n_fail++; $display("FAIL abort_outputs: got data=%h wr=%b rd=%b expected 0000 0 0",
                         dataout, doneWrite, doneRead);
    end
    tick();
    n_checks++;
    if (doneWrite !== 1'b0) begin
      n_fail++; $display("FAIL abort_no_done: got %b expected 0", doneWrite);
    end
    RST = 1'b1;
    tick();
    do_read(16'd6, cyc);
    n_checks++;
    if (dataout !== 16'h6666) begin
      n_fail++; $display("FAIL abort_word_kept: got %h expected 6666", dataout);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic exp_rd;
    address = 16'd9; read_signal = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      exp_rd = ((k % 3) == 0);
      n_checks++;
      if (doneRead !== exp_rd || doneWrite !== 1'b0) begin
        n_fail++; $display("FAIL b2b_tick%0d: got rd=%b wr=%b expected rd=%b wr=0",
                           k, doneRead, doneWrite, exp_rd);
      end
    end
    read_signal = 1'b0;
    n_checks++;
    if (dataout !== 16'hA001) begin
      n_fail++; $display("FAIL b2b_data: got %h expected a001", dataout);
    end
    tick();
  endtask

  task automatic test_out_of_range();
    int cyc;
    do_write(16'd0, 16'h0A0A, cyc);
    tick();
    do_write(16'h0400, 16'hBBBB, cyc);
    n_checks++;
    if (cyc != 3) begin
      n_fail++; $display("FAIL oor_write_done: got %0d ticks expected 3", cyc);
    end
    tick();
`ifdef DMA_ADDR_CHECK_EN
    do_read(16'h0400, cyc);
    n_checks++;
    if (cyc != 3 || dataout !== 16'h0000) begin
      n_fail++; $display("FAIL oor_read_zero: got %h after %0d ticks expected 0000 after 3",
                         dataout, cyc);
    end
    tick();
    do_read(16'd0, cyc);
    n_checks++;
    if (dataout !== 16'h0A0A) begin
      n_fail++; $display("FAIL oor_addr0_kept: got %h expected 0a0a", dataout);
    end
`else
    do_read(16'd0, cyc);
    n_checks++;
    if (dataout !== 16'hBBBB) begin
      n_fail++; $display("FAIL oor_alias_addr0: got %h expected bbbb", dataout);
    end
    tick();
    do_read(16'h0400, cyc);
    n_checks++;
    if (dataout !== 16'hBBBB) begin
      n_fail++; $display("FAIL oor_alias_read: got %h expected bbbb", dataout);
    end
`endif
    tick();
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    RST = 1'b0; address = '0; data = '0;
    read_signal = 1'b0; write_signal = 1'b0;
    test_reset();
    test_write_readback();
    test_latency();
    test_priority();
    test_midop_change();
    test_reset_abort();
    test_back_to_back();
    test_out_of_range();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
